// File: rtl/controlador_de_partida_if.sv
// Link between the game controller and the attack manager: target selection,
// map/matrix lookups and the enable/attack-strobe pair.
interface controlador_de_partida_if;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic       alvo_na_coord;
  logic       ja_revelado;
  logic [5:0] total_alvos;
  logic       tem_vida;
  logic       enable;
  logic       confirmar;

  modport master (
    input  coordColuna, coordLinha, alvo_na_coord, ja_revelado, total_alvos, tem_vida,
    output enable, confirmar
  );

  modport slave (
    output coordColuna, coordLinha, alvo_na_coord, ja_revelado, total_alvos, tem_vida,
    input  enable, confirmar
  );
endinterface

// File: rtl/controlador_de_partida.sv
// Battleship game controller: debounces the two pushbuttons and sequences
// start, attack, evaluation and end-of-game states.
module controlador_de_partida #(
  parameter int DEBOUNCE = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           btn_iniciar,
  input  logic                           btn_confirmar,
  controlador_de_partida_if.master       bus,
  output logic [2:0]                     estado,
  output logic [5:0]                     acertos,
  output logic                           vitoria,
  output logic                           derrota,
  output logic                           coord_invalida
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    JOGANDO = 3'd1,
    ATAQUE  = 3'd2,
    AVALIA  = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } estado_t;

  localparam logic [7:0] LIMITE = 8'(DEBOUNCE - 1);

  function automatic logic [5:0] soma_saturada(input logic [5:0] valor, input logic inc);
    if (inc && (valor < 6'd35)) return valor + 6'd1;
    else                        return valor;
  endfunction

  logic [1:0] btn_s;
  logic [1:0] evt_s;
  logic [7:0] cnt_r   [2];
  logic [1:0] trava_r;

  estado_t    estado_r;
  logic       enable_r;
  logic       confirmar_r;
  logic [5:0] acertos_r;
  logic       vitoria_r;
  logic       derrota_r;
  logic       coord_invalida_r;
  logic       hit_pend_r;
  logic [5:0] total_r;
  logic       coord_ok_s;

  assign btn_s      = {btn_confirmar, btn_iniciar};
  assign coord_ok_s = (bus.coordColuna <= 3'd4) && (bus.coordLinha <= 3'd6);

  // The lock comes out of reset set so a button held through reset must be released first.
  for (genvar g = 0; g < 2; g++) begin : g_debounce
    // Per-button stable-high counter and one-event-per-press lock.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_r[g]   <= 8'd0;
        trava_r[g] <= 1'b1;
      end else if (!btn_s[g]) begin
        cnt_r[g]   <= 8'd0;
        trava_r[g] <= 1'b0;
      end else if (trava_r[g]) begin
        cnt_r[g]   <= 8'd0;
      end else if (cnt_r[g] == LIMITE) begin
        cnt_r[g]   <= 8'd0;
        trava_r[g] <= 1'b1;
      end else begin
        cnt_r[g]   <= cnt_r[g] + 8'd1;
      end
    end

    assign evt_s[g] = btn_s[g] & ~trava_r[g] & (cnt_r[g] == LIMITE);
  end

  // Game FSM; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r         <= OCIOSO;
      enable_r         <= 1'b0;
      confirmar_r      <= 1'b0;
      acertos_r        <= 6'd0;
      vitoria_r        <= 1'b0;
      derrota_r        <= 1'b0;
      coord_invalida_r <= 1'b0;
      hit_pend_r       <= 1'b0;
      total_r          <= 6'd0;
    end else begin
      confirmar_r      <= 1'b0;
      coord_invalida_r <= 1'b0;
      case (estado_r)
        OCIOSO: begin
          if (evt_s[0] && (bus.total_alvos != 6'd0)) begin
            estado_r  <= JOGANDO;
            enable_r  <= 1'b1;
            acertos_r <= 6'd0;
            total_r   <= bus.total_alvos;
          end
        end
        JOGANDO: begin
          if (evt_s[0]) begin
            estado_r <= OCIOSO;
            enable_r <= 1'b0;
          end else if (evt_s[1] && coord_ok_s) begin
            estado_r    <= ATAQUE;
            confirmar_r <= 1'b1;
            hit_pend_r  <= bus.alvo_na_coord & ~bus.ja_revelado;
          end else if (evt_s[1]) begin
            coord_invalida_r <= 1'b1;
          end
        end
        ATAQUE: begin
          acertos_r <= soma_saturada(acertos_r, hit_pend_r);
          estado_r  <= AVALIA;
        end
        AVALIA: begin
          if (acertos_r == total_r) begin
            estado_r  <= VITORIA;
            vitoria_r <= 1'b1;
          end else if (!bus.tem_vida) begin
            estado_r  <= DERROTA;
            derrota_r <= 1'b1;
          end else begin
            estado_r  <= JOGANDO;
          end
        end
        VITORIA, DERROTA: begin
          if (evt_s[0]) begin
            estado_r  <= OCIOSO;
            enable_r  <= 1'b0;
            vitoria_r <= 1'b0;
            derrota_r <= 1'b0;
          end
        end
        default: begin
          estado_r  <= OCIOSO;
          enable_r  <= 1'b0;
          vitoria_r <= 1'b0;
          derrota_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable     = enable_r;
  assign bus.confirmar  = confirmar_r;
  assign estado         = estado_r;
  assign acertos        = acertos_r;
  assign vitoria        = vitoria_r;
  assign derrota        = derrota_r;
  assign coord_invalida = coord_invalida_r;

endmodule

// File: tb/tb_controlador_de_partida.sv
// Directed bench for controlador_de_partida with DEBOUNCE=3.
module tb_controlador_de_partida;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_iniciar;
  logic       btn_confirmar;
  logic [2:0] estado;
  logic [5:0] acertos;
  logic       vitoria;
  logic       derrota;
  logic       coord_invalida;

  int n_cmp = 0;
  int n_err = 0;

  controlador_de_partida_if bus_if ();

  controlador_de_partida #(.DEBOUNCE(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_iniciar    (btn_iniciar),
    .btn_confirmar  (btn_confirmar),
    .bus            (bus_if),
    .estado         (estado),
    .acertos        (acertos),
    .vitoria        (vitoria),
    .derrota        (derrota),
    .coord_invalida (coord_invalida)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Holds a button high for exactly DEBOUNCE cycles; leaves it high.
  task automatic press_ini();
    btn_iniciar = 1'b1;
    repeat (3) tick();
  endtask

  task automatic press_conf();
    btn_confirmar = 1'b1;
    repeat (3) tick();
  endtask

  task automatic release_all();
    btn_iniciar   = 1'b0;
    btn_confirmar = 1'b0;
    tick();
  endtask

  task automatic set_coord(input logic [2:0] col, input logic [2:0] lin,
                           input logic alvo, input logic revelado);
    bus_if.coordColuna   = col;
    bus_if.coordLinha    = lin;
    bus_if.alvo_na_coord = alvo;
    bus_if.ja_revelado   = revelado;
  endtask

  initial begin
    reset         = 1'b1;
    btn_iniciar   = 1'b0;
    btn_confirmar = 1'b0;
    bus_if.total_alvos = 6'd0;
    bus_if.tem_vida    = 1'b1;
    set_coord(3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_estado", 8'(estado), 8'd0);
    chk("rst_enable", 8'(bus_if.enable), 8'd0);
    chk("rst_confirmar", 8'(bus_if.confirmar), 8'd0);
    chk("rst_acertos", 8'(acertos), 8'd0);
    chk("rst_vit_der_inv", 8'({vitoria, derrota, coord_invalida}), 8'd0);
    reset = 1'b0;
    tick();

    // Short press: two cycles only
    bus_if.total_alvos = 6'd4;
    btn_iniciar = 1'b1;
    tick();
    tick();
    release_all();
    chk("short_press", 8'(estado), 8'd0);

    // Start
    press_ini();
    chk("start_estado", 8'(estado), 8'd1);
    chk("start_enable", 8'(bus_if.enable), 8'd1);
    chk("start_acertos", 8'(acertos), 8'd0);
    release_all();

    // Hit at (0,0)
    set_coord(3'd0, 3'd0, 1'b1, 1'b0);
    press_conf();
    chk("hit_ataque", 8'(estado), 8'd2);
    chk("hit_strobe", 8'(bus_if.confirmar), 8'd1);
    release_all();
    chk("hit_strobe_off", 8'(bus_if.confirmar), 8'd0);
    chk("hit_avalia", 8'(estado), 8'd3);
    chk("hit_acertos", 8'(acertos), 8'd1);
    tick();
    chk("hit_back", 8'(estado), 8'd1);

    // Same cell again, already revealed
    set_coord(3'd0, 3'd0, 1'b1, 1'b1);
    press_conf();
    chk("rep_strobe", 8'(bus_if.confirmar), 8'd1);
    release_all();
    tick();
    chk("rep_acertos", 8'(acertos), 8'd1);
    chk("rep_estado", 8'(estado), 8'd1);

    // Invalid column 5
    set_coord(3'd5, 3'd0, 1'b1, 1'b0);
    press_conf();
    chk("inv_pulse", 8'(coord_invalida), 8'd1);
    chk("inv_strobe", 8'(bus_if.confirmar), 8'd0);
    chk("inv_estado", 8'(estado), 8'd1);
    release_all();
    chk("inv_pulse_end", 8'(coord_invalida), 8'd0);

    // Invalid row 7
    set_coord(3'd4, 3'd7, 1'b1, 1'b0);
    press_conf();
    chk("inv_row", 8'(coord_invalida), 8'd1);
    release_all();

    // Abort, then restart with two targets
    press_ini();
    chk("abort_estado", 8'(estado), 8'd0);
    chk("abort_enable", 8'(bus_if.enable), 8'd0);
    release_all();
    bus_if.total_alvos = 6'd2;
    press_ini();
    chk("restart_estado", 8'(estado), 8'd1);
    release_all();
    bus_if.total_alvos = 6'd5;

    // Two distinct hits; last one with no lives left
    set_coord(3'd1, 3'd1, 1'b1, 1'b0);
    press_conf();
    release_all();
    tick();
    chk("v_hit1", 8'(acertos), 8'd1);
    set_coord(3'd4, 3'd6, 1'b1, 1'b0);
    bus_if.tem_vida = 1'b0;
    press_conf();
    release_all();
    tick();
    chk("v_estado", 8'(estado), 8'd4);
    chk("v_vitoria", 8'(vitoria), 8'd1);
    chk("v_derrota", 8'(derrota), 8'd0);
    chk("v_enable", 8'(bus_if.enable), 8'd1);

    // Confirm ignored after victory
    press_conf();
    chk("v_conf_ign", 8'({estado, bus_if.confirmar}), 8'({3'd4, 1'b0}));
    release_all();
    press_ini();
    chk("v_exit", 8'({estado, bus_if.enable, vitoria}), 8'd0);
    release_all();

    // Defeat on a miss
    bus_if.total_alvos = 6'd4;
    bus_if.tem_vida    = 1'b1;
    press_ini();
    release_all();
    set_coord(3'd3, 3'd6, 1'b0, 1'b0);
    bus_if.tem_vida = 1'b0;
    press_conf();
    release_all();
    tick();
    chk("d_estado", 8'(estado), 8'd5);
    chk("d_derrota", 8'(derrota), 8'd1);
    chk("d_enable", 8'(bus_if.enable), 8'd1);
    chk("d_acertos", 8'(acertos), 8'd0);
    press_ini();
    chk("d_exit", 8'({estado, bus_if.enable, derrota}), 8'd0);
    release_all();

    // Zero targets: start ignored
    bus_if.total_alvos = 6'd0;
    press_ini();
    chk("zero_targets", 8'(estado), 8'd0);
    release_all();

    // Reset during ATAQUE with buttons held
    bus_if.total_alvos = 6'd4;
    bus_if.tem_vida    = 1'b1;
    press_ini();
    release_all();
    set_coord(3'd2, 3'd2, 1'b1, 1'b0);
    press_conf();
    chk("r_ataque", 8'(estado), 8'd2);
    btn_iniciar = 1'b1;
    reset = 1'b1;
    tick();
    chk("r_estado", 8'(estado), 8'd0);
    chk("r_outs", 8'({bus_if.enable, bus_if.confirmar, vitoria, derrota, coord_invalida}), 8'd0);
    chk("r_acertos", 8'(acertos), 8'd0);
    reset = 1'b0;
    repeat (4) tick();
    chk("r_held_no_evt", 8'(estado), 8'd0);
    release_all();
    press_ini();
    chk("r_repress", 8'(estado), 8'd1);
    release_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
